// File: rtl/fifo_show_ahead_drain.sv
// Read-side drain controller for a show-ahead FIFO. It accumulates words until a
// threshold, full, timeout or flush, then streams them out through a 2-entry skid buffer.
module fifo_show_ahead_drain #(
  parameter int DATA_W    = 11,
  parameter int USEDW_W   = 8,
  parameter int BURST_MIN = 16,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_enable,
  input  logic               flush,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   words_drained,
  output logic               busy
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [USEDW_W-1:0] BURST_LVL  = USEDW_W'(BURST_MIN);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [1:0]         occ;
  logic [DATA_W-1:0]  head, tail;
  logic               push, pop, drain_start;

  // Pop depends only on registered state/occupancy, never on out_ready.
  assign fifo_rdreq  = (state == DRAIN) && !fifo_empty && (occ != 2'd2) && !reset;
  assign push        = fifo_rdreq;
  assign out_valid   = (occ != 2'd0);
  assign pop         = out_valid && out_ready;
  assign out_data    = head;
  assign busy        = (state != IDLE) || (occ != 2'd0);
  // fifo_full is needed because usedw wraps to 0 when the FIFO is full.
  assign drain_start = (fifo_usedw >= BURST_LVL) || fifo_full || flush || (timer == TIMER_LAST);

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      IDLE: begin
        if (cfg_enable && !fifo_empty) begin
          state_next = ACCUM;
          timer_next = '0;
        end
      end
      ACCUM: begin
        if (!cfg_enable)      state_next = IDLE;
        else if (drain_start) state_next = DRAIN;
        else                  timer_next = timer + 1'b1;
      end
      DRAIN: begin
        if (fifo_empty || !cfg_enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      occ           <= 2'd0;
      head          <= '0;
      tail          <= '0;
      words_drained <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      // head is always the oldest entry; tail only fills when head is held.
      if (push && ((occ == 2'd0) || pop)) head <= fifo_q;
      else if (pop)                       head <= tail;
      if (push && (occ == 2'd1) && !pop)  tail <= fifo_q;
      if (pop) words_drained <= words_drained + 1'b1;
    end
  end

endmodule
